// File: rtl/constraint_sweep.sv
// constraint_sweep: Gauss-Seidel relaxation sequencer for a chain of
// N_POINTS Q16.16 (x,y) points. Each interior point is presented to an
// external combinational constraint solver together with its two
// neighbours. The solver result is written back in place, so later points
// in the same sweep see the updated values.
//
// Optional feature macro: CONSTRAINT_SWEEP_ALTDIR_EN
//   When defined, odd iterations sweep from N_POINTS-2 down to 1 instead
//   of upward. The cycle count is the same in both directions.
module constraint_sweep #(
  parameter int N_POINTS   = 8,
  parameter int ITERATIONS = 4,
  parameter int IDX_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [31:0]       wr_x,
  input  logic [31:0]       wr_y,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [31:0]       rd_x,
  output logic [31:0]       rd_y,
  output logic [31:0]       ec_up_x,
  output logic [31:0]       ec_up_y,
  output logic [31:0]       ec_x,
  output logic [31:0]       ec_y,
  output logic [31:0]       ec_down_x,
  output logic [31:0]       ec_down_y,
  input  logic [31:0]       ec_x_res,
  input  logic [31:0]       ec_y_res
);

  // Width of the storage address; the low bits of the index ports select
  // an entry once the full-width index has been range-checked.
  localparam int AW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINTS - 1);
  localparam logic [IDX_W-1:0] HI_IDX    = IDX_W'(N_POINTS - 2);
  localparam logic [IDX_W-1:0] LO_IDX    = IDX_W'(1);
  localparam logic [7:0]       ITER_LAST = 8'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       iter_q, iter_d;

  logic [31:0] ec_up_x_q, ec_up_y_q, ec_x_q, ec_y_q, ec_down_x_q, ec_down_y_q;

  // Point storage, gathered from the per-point registers below.
  logic [31:0] pt_x [N_POINTS];
  logic [31:0] pt_y [N_POINTS];

  logic sweep_down;   // current iteration runs N_POINTS-2 -> 1
  logic next_down;    // direction of the iteration that follows
  logic sweep_last;   // current idx is the final point of this sweep
  logic wr_ok;        // host write accepted this cycle

`ifdef CONSTRAINT_SWEEP_ALTDIR_EN
  assign sweep_down = iter_q[0];
  assign next_down  = ~iter_q[0];
`else
  assign sweep_down = 1'b0;
  assign next_down  = 1'b0;
`endif

  assign sweep_last = sweep_down ? (idx_q == LO_IDX) : (idx_q == HI_IDX);
  assign wr_ok      = (state_q == IDLE) && wr_en && (wr_idx <= LAST_IDX);

  // Neighbour addresses; idx is always interior during a sweep, so the
  // +/-1 never leaves the array.
  logic [AW-1:0] idx_lo, idx_m1, idx_p1;
  assign idx_lo = idx_q[AW-1:0];
  assign idx_m1 = idx_lo - 1'b1;
  assign idx_p1 = idx_lo + 1'b1;

  // State, point index and iteration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state, index stepping and status outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = LO_IDX;
          iter_d  = '0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        busy    = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (!sweep_last) begin
          idx_d   = sweep_down ? (idx_q - 1'b1) : (idx_q + 1'b1);
          state_d = PRESENT;
        end else if (iter_q < ITER_LAST) begin
          iter_d  = iter_q + 1'b1;
          idx_d   = next_down ? HI_IDX : LO_IDX;
          state_d = PRESENT;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Solver operand registers, loaded with the current point and its
  // neighbours while presenting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ec_up_x_q   <= '0;
      ec_up_y_q   <= '0;
      ec_x_q      <= '0;
      ec_y_q      <= '0;
      ec_down_x_q <= '0;
      ec_down_y_q <= '0;
    end else if (state_q == PRESENT) begin
      ec_up_x_q   <= pt_x[idx_m1];
      ec_up_y_q   <= pt_y[idx_m1];
      ec_x_q      <= pt_x[idx_lo];
      ec_y_q      <= pt_y[idx_lo];
      ec_down_x_q <= pt_x[idx_p1];
      ec_down_y_q <= pt_y[idx_p1];
    end
  end

  assign ec_up_x   = ec_up_x_q;
  assign ec_up_y   = ec_up_y_q;
  assign ec_x      = ec_x_q;
  assign ec_y      = ec_y_q;
  assign ec_down_x = ec_down_x_q;
  assign ec_down_y = ec_down_y_q;

  // One register pair per point. Anchors have no capture path at all, so
  // a sweep can never move them.
  for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_pt
    localparam bit INTERIOR = (gi != 0) && (gi != N_POINTS - 1);

    logic [31:0] x_q, y_q;
    logic        load_hit, cap_hit;

    assign load_hit = wr_ok && (wr_idx == IDX_W'(gi));
    assign cap_hit  = INTERIOR && (state_q == CAPTURE) && (idx_q == IDX_W'(gi));

    // Host load in IDLE, solver writeback in CAPTURE.
    always_ff @(posedge clk) begin
      if (rst) begin
        x_q <= '0;
        y_q <= '0;
      end else if (load_hit) begin
        x_q <= wr_x;
        y_q <= wr_y;
      end else if (cap_hit) begin
        x_q <= ec_x_res;
        y_q <= ec_y_res;
      end
    end

    assign pt_x[gi] = x_q;
    assign pt_y[gi] = y_q;
  end

  // Combinational readback; out-of-range indices read as zero.
  assign rd_x = (rd_idx <= LAST_IDX) ? pt_x[rd_idx[AW-1:0]] : '0;
  assign rd_y = (rd_idx <= LAST_IDX) ? pt_y[rd_idx[AW-1:0]] : '0;

endmodule

// File: tb/tb_constraint_sweep.sv
// Directed bench for constraint_sweep with a behavioural stub solver.
module tb_constraint_sweep;

  localparam int NP = 8;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, wr_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [31:0]   wr_x, wr_y, rd_x, rd_y;
  logic [31:0]   ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y;
  logic [31:0]   ec_x_res, ec_y_res;

  // 0: x+1.0, 1: copy upper neighbour x, other: identity
  int mode;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  constraint_sweep #(.N_POINTS(NP), .ITERATIONS(4), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .ec_up_x(ec_up_x), .ec_up_y(ec_up_y), .ec_x(ec_x), .ec_y(ec_y),
    .ec_down_x(ec_down_x), .ec_down_y(ec_down_y),
    .ec_x_res(ec_x_res), .ec_y_res(ec_y_res)
  );

  // Stub constraint solver
  always_comb begin
    ec_x_res = ec_x;
    ec_y_res = ec_y;
    if (mode == 0) ec_x_res = ec_x + 32'h0001_0000;
    else if (mode == 1) ec_x_res = ec_up_x;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("  ok   %s = %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] x, input logic [31:0] y);
    wr_en  = 1'b1;
    wr_idx = IW'(idx);
    wr_x   = x;
    wr_y   = y;
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic check_pt(input string tag, input int idx, input logic [31:0] ex, input logic [31:0] ey);
    rd_idx = IW'(idx);
    #1;
    check_val($sformatf("%s x[%0d]", tag, idx), rd_x, ex);
    check_val($sformatf("%s y[%0d]", tag, idx), rd_y, ey);
  endtask

  // Pulse start; returns in cycle 1 of the run.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sample status for ncyc cycles starting at the current cycle (numbered 1).
  task automatic observe(input int ncyc, output int busy_cnt, output int done_cnt, output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      tick();
    end
  endtask

  int bc, dc, da;

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0;
    wr_idx = '0; wr_x = '0; wr_y = '0; rd_idx = '0; mode = 2;

    // Reset state
    do_reset();
    check_val("rst busy", {31'b0, busy}, 32'd0);
    check_val("rst done", {31'b0, done}, 32'd0);
    check_val("rst ec_up_x", ec_up_x, 32'd0);
    check_val("rst ec_up_y", ec_up_y, 32'd0);
    check_val("rst ec_x", ec_x, 32'd0);
    check_val("rst ec_y", ec_y, 32'd0);
    check_val("rst ec_down_x", ec_down_x, 32'd0);
    check_val("rst ec_down_y", ec_down_y, 32'd0);
    for (int i = 0; i < NP; i++) check_pt("rst", i, 32'd0, 32'd0);

    // Latency and +1.0 stub: four sweeps add 4.0 to each interior x
    mode = 0;
    for (int i = 0; i < NP; i++) load(i, 32'd0, 32'(i * 32'h111));
    start_run();
    observe(60, bc, dc, da);
    check_val("lat busy cycles", 32'(bc), 32'd48);
    check_val("lat done pulses", 32'(dc), 32'd1);
    check_val("lat done cycle", 32'(da), 32'd49);
    for (int i = 0; i < NP; i++)
      check_pt("inc", i, (i == 0 || i == NP - 1) ? 32'd0 : 32'h0004_0000, 32'(i * 32'h111));
    rd_idx = IW'(8);  #1; check_val("rd oob 8", rd_x, 32'd0);
    rd_idx = IW'(63); #1; check_val("rd oob 63", rd_y, 32'd0);

    // Ordering: copy-up stub gives zeros everywhere in Gauss-Seidel order
    do_reset();
    mode = 1;
    for (int i = 0; i < NP; i++) load(i, 32'(i) << 16, 32'(i));
    start_run();
    tick();
    check_val("ord c2 ec_up_x", ec_up_x, 32'd0);
    check_val("ord c2 ec_x", ec_x, 32'h0001_0000);
    check_val("ord c2 ec_down_x", ec_down_x, 32'h0002_0000);
    tick();
    tick();
    check_val("ord c4 ec_up_x", ec_up_x, 32'd0);
    check_val("ord c4 ec_x", ec_x, 32'h0002_0000);
    check_val("ord c4 ec_down_x", ec_down_x, 32'h0003_0000);
    observe(60, bc, dc, da);
    check_val("ord done pulses", 32'(dc), 32'd1);
    for (int i = 0; i < NP; i++)
      check_pt("ord", i, (i == NP - 1) ? 32'h0007_0000 : 32'd0, 32'(i));

    // Reset after a run clears operands and storage
    do_reset();
    check_val("rst2 ec_down_x", ec_down_x, 32'd0);
    check_pt("rst2", NP - 1, 32'd0, 32'd0);

    // Illegal access: writes and starts while busy, out-of-range writes
    mode = 2;
    load(3, 32'h0003_0000, 32'h33);
    load(8, 32'h0000_0BAD, 32'h0BAD);
    load(63, 32'h0000_0BAD, 32'h0BAD);
    check_pt("oob wr", 0, 32'd0, 32'd0);
    start_run();
    bc = 0; dc = 0;
    for (int c = 1; c <= 60; c++) begin
      wr_en  = (c < 20);
      wr_idx = IW'(3);
      wr_x   = 32'hDEAD_BEEF;
      wr_y   = 32'hDEAD_BEEF;
      start  = (c < 40) && (c % 2 == 0);
      if (done) dc++;
      tick();
    end
    wr_en = 1'b0;
    start = 1'b0;
    check_val("busy-start done pulses", 32'(dc), 32'd1);
    check_pt("busy-wr", 3, 32'h0003_0000, 32'h33);

    // Write and start in the same IDLE cycle
    do_reset();
    mode = 0;
    wr_en = 1'b1; wr_idx = IW'(2); wr_x = 32'h0010_0000; wr_y = 32'h7;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    observe(60, bc, dc, da);
    check_val("wr+start done pulses", 32'(dc), 32'd1);
    check_pt("wr+start", 2, 32'h0014_0000, 32'h7);
    check_pt("wr+start", 1, 32'h0004_0000, 32'd0);

    // start held high restarts on the first IDLE cycle after DONE
    do_reset();
    mode = 2;
    start = 1'b1;
    tick();
    for (int c = 1; c < 49; c++) tick();
    check_val("held c49 done", {31'b0, done}, 32'd1);
    tick();
    check_val("held c50 busy", {31'b0, busy}, 32'd0);
    check_val("held c50 done", {31'b0, done}, 32'd0);
    tick();
    check_val("held c51 busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    observe(60, bc, dc, da);
    check_val("held 2nd done pulses", 32'(dc), 32'd1);

    // Abort: reset in cycle 10 of a run
    do_reset();
    mode = 0;
    for (int i = 0; i < NP; i++) load(i, 32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i));
    start_run();
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    check_val("abort busy", {31'b0, busy}, 32'd0);
    check_val("abort ec_x", ec_x, 32'd0);
    rst = 1'b0;
    observe(60, bc, dc, da);
    check_val("abort done pulses", 32'(dc), 32'd0);
    check_val("abort busy cycles", 32'(bc), 32'd0);
    for (int i = 0; i < NP; i++) check_pt("abort", i, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/constraint_sweep.md
CONSTRAINT_SWEEP -- requirements
Module: constraint_sweep

Interface
REQ-001 SHALL have parameter N_POINTS, default 8: number of chain points; legal range 3..64.
REQ-002 SHALL have parameter ITERATIONS, default 4: number of full relaxation sweeps per start; legal range 1..255.
REQ-003 SHALL have parameter IDX_W, default 6: width of point index ports.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: begin a relaxation run when idle.
REQ-007 SHALL have port busy, output, 1: high while sweeping.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when a run completes.
REQ-009 SHALL have ports wr_en (input, 1), wr_idx (input, IDX_W), wr_x and wr_y (input, 32 each): load one point's Q16.16 position.
REQ-010 SHALL have ports rd_idx (input, IDX_W), rd_x and rd_y (output, 32 each): combinational readback of the stored point.
REQ-011 SHALL have ports ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y (output, 32 each, registered): operands driven to the external constraint solver.
REQ-012 SHALL have ports ec_x_res and ec_y_res (input, 32 each): solver results, combinational from the ec_* outputs.

Function
REQ-013 SHALL store N_POINTS (x,y) pairs as 32-bit Q16.16; index 0 is the top anchor, index N_POINTS-1 the bottom.
REQ-014 SHALL use FSM states IDLE, PRESENT, CAPTURE, DONE; reset state is IDLE.
REQ-015 IDLE: when start=1, SHALL load the point index with 1 and the iteration counter with 0, then go to PRESENT.
REQ-016 PRESENT: SHALL register points idx-1, idx, idx+1 onto ec_up_*, ec_*, ec_down_*, then go to CAPTURE.
REQ-017 CAPTURE: SHALL write ec_x_res/ec_y_res into point idx (Gauss-Seidel); the next PRESENT therefore sees the updated value.
REQ-018 After CAPTURE, if idx < N_POINTS-2, SHALL increment idx and go to PRESENT; otherwise, if the iteration counter < ITERATIONS-1, SHALL increment the counter, reset idx to 1 and go to PRESENT; otherwise SHALL go to DONE.
REQ-019 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 in PRESENT and CAPTURE, 0 in IDLE and DONE.
REQ-021 Latency: done SHALL be high in the cycle 2*(N_POINTS-2)*ITERATIONS+1 cycles after the edge that sampled start.
REQ-022 Anchors (index 0 and N_POINTS-1) SHALL never be written by a sweep.
REQ-023 start SHALL be ignored outside IDLE; start held high SHALL begin a new run on the first IDLE cycle after DONE.
REQ-024 wr_en SHALL write only in IDLE; it SHALL be ignored in all other states; wr_idx >= N_POINTS SHALL be ignored.
REQ-025 If wr_en and start occur in the same IDLE cycle, the write SHALL take effect and the run SHALL see the written value.
REQ-026 rd_idx >= N_POINTS SHALL return 0 on rd_x/rd_y; readback SHALL be valid in every state.

Reset
REQ-027 On rst=1, SHALL enter IDLE; busy=0, done=0, all ec_* outputs=0, all stored points=0, counters=0.
REQ-028 rst mid-run SHALL abort at that edge with no further writeback; done SHALL not pulse.

Configuration
REQ-029 With macro CONSTRAINT_SWEEP_ALTDIR_EN defined, odd-numbered iterations (counter 1,3,...) SHALL sweep from idx N_POINTS-2 down to 1; even iterations sweep upward; cycle count is unchanged.
REQ-030 Without CONSTRAINT_SWEEP_ALTDIR_EN, every iteration SHALL sweep upward from 1 to N_POINTS-2.

Verification
REQ-031 Reset: assert rst for 2 cycles -> busy=0, done=0, all ec_*=0, rd_x/rd_y=0 for every index.
REQ-032 Latency: N_POINTS=8, ITERATIONS=4, start pulse -> busy high for 48 cycles, done high in cycle 49 only.
REQ-033 Stub solver returning ec_x+32'h00010000, ec_y unchanged; load all x=0 -> after run, points 1..6 have x=32'h00040000, points 0 and 7 have x=0.
REQ-034 Ordering: stub solver returning ec_up_x; load x[i]=i<<16 -> without the macro all interior x=0 after one iteration; with CONSTRAINT_SWEEP_ALTDIR_EN, iteration 1 (second sweep) ends with point 6 = 0.
REQ-035 Illegal access: wr_en with wr_idx=3 during busy -> point 3 unchanged; start during busy -> done pulses once only.
REQ-036 Abort: rst at cycle 10 of a run -> busy=0 next cycle, no done pulse, all points read 0.
